// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU operand-issue stage: command encodings,
// default widths and the immediate sign-extension helper.
package alu_issue_pkg;

  localparam int N_DEF  = 32;
  localparam int RA_DEF = 4;
  localparam int IW_DEF = 16;

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_XOR = 4'd4;
  localparam logic [3:0] CMD_NOR = 4'd5;
  localparam logic [3:0] CMD_NOT = 4'd6;
  localparam logic [3:0] CMD_SLA = 4'd7;
  localparam logic [3:0] CMD_SRL = 4'd8;
  localparam logic [3:0] CMD_SRA = 4'd9;
  localparam logic [3:0] CMD_INC = 4'd10;
  localparam logic [3:0] CMD_DEC = 4'd11;
  localparam logic [3:0] CMD_SLT = 4'd12;
  localparam logic [3:0] CMD_SGT = 4'd13;
  localparam logic [3:0] CMD_LUI = 4'd14;
  localparam logic [3:0] CMD_HAM = 4'd15;

  // Sign-extends the low w bits of v to the full N_DEF width.
  function automatic logic [N_DEF-1:0] sext(input logic [N_DEF-1:0] v, input int w);
    logic signed [N_DEF-1:0] t;
    t = signed'(v << (N_DEF - w));
    return unsigned'(t >>> (N_DEF - w));
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two combinational read ports, one synchronous write port; R0 is hard zero.
module regfile_2r1w #(
  parameter int N  = 32,
  parameter int RA = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RA-1:0] ra_addr,
  output logic [N-1:0]  ra_data,
  input  logic [RA-1:0] rb_addr,
  output logic [N-1:0]  rb_data,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [N-1:0]  wdata
);

  localparam int NREG = 2**RA;

  logic [N-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents; any bypass lives in the issue stage.
  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage feeding the ALU: regfile read, immediate select, scoreboard
// hazard stall. Define ALU_ISSUE_FWD_EN to bypass writeback data to same-cycle sources.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int RA = RA_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_cmd,
  input  logic [RA-1:0] in_rs,
  input  logic [RA-1:0] in_rt,
  input  logic [RA-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_use_imm,
  input  logic [IW-1:0] in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  A,
  output logic [N-1:0]  B,
  output logic [3:0]    CMD,
  output logic [RA-1:0] out_rd,
  output logic          out_we,
  input  logic          wb_en,
  input  logic [RA-1:0] wb_rd,
  input  logic [N-1:0]  wb_data
);

  localparam int NREG = 2**RA;

  logic [N-1:0]    rf_a, rf_b, src_a, src_b, imm_ext;
  logic [NREG-1:0] pend, pend_nxt;
  logic            byp_a, byp_b, busy_a, busy_b, waw, hazard, accept;

  regfile_2r1w #(.N(N), .RA(RA)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (in_rs),
    .ra_data (rf_a),
    .rb_addr (in_rt),
    .rb_data (rf_b),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

`ifdef ALU_ISSUE_FWD_EN
  // A source being written back this cycle is satisfied by the writeback value.
  assign byp_a = wb_en && (wb_rd == in_rs) && (in_rs != '0);
  assign byp_b = wb_en && (wb_rd == in_rt) && (in_rt != '0);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign src_a   = byp_a ? wb_data : rf_a;
  assign src_b   = byp_b ? wb_data : rf_b;
  assign imm_ext = N'(sext(N_DEF'(in_imm), IW));

  assign busy_a = (in_rs != '0) && pend[in_rs] && !byp_a;
  assign busy_b = (in_rt != '0) && pend[in_rt] && !byp_b;
  assign waw    = in_we && (in_rd != '0) && pend[in_rd];
  assign hazard = busy_a || (!in_use_imm && busy_b) || waw;

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Writeback clears, a new issue sets; the set is applied last so it wins.
  always_comb begin
    pend_nxt = pend;
    if (wb_en && wb_rd != '0) pend_nxt[wb_rd] = 1'b0;
    if (accept && in_we && in_rd != '0) pend_nxt[in_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Issue register: one-cycle latency from accept to the ALU operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      CMD       <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        A         <= src_a;
        B         <= in_use_imm ? imm_ext : src_b;
        CMD       <= in_cmd;
        out_rd    <= in_rd;
        out_we    <= in_we;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a register/scoreboard reference model.
// Compile with ALU_ISSUE_FWD_EN defined to exercise the bypass variant.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_we, in_use_imm;
  logic [3:0]  in_cmd, in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic        out_valid, out_ready, out_we;
  logic [31:0] A, B;
  logic [3:0]  CMD, out_rd;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_we(in_we),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .CMD(CMD), .out_rd(out_rd), .out_we(out_we),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Reference state: architectural registers, outstanding-write set, output slot.
  logic [31:0] mreg [16];
  bit          mpend [16];
  bit          mvalid, mwe;
  logic [31:0] mA, mB;
  logic [3:0]  mcmd, mrd;
  logic [3:0]  wbq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit busy(input logic [3:0] r);
    bit b;
    b = (r != 0) && mpend[r];
`ifdef ALU_ISSUE_FWD_EN
    if (wb_en && wb_rd == r) b = 0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] srcval(input logic [3:0] r);
    if (r == 0) return 32'h0;
`ifdef ALU_ISSUE_FWD_EN
    if (wb_en && wb_rd == r) return wb_data;
`endif
    return mreg[r];
  endfunction

  function automatic bit exp_ready();
    bit haz;
    haz = busy(in_rs) || (!in_use_imm && busy(in_rt)) || (in_we && in_rd != 0 && mpend[in_rd]);
    return (!mvalid || out_ready) && !haz;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mreg[i] = 0;
      mpend[i] = 0;
    end
    mvalid = 0; mwe = 0; mA = 0; mB = 0; mcmd = 0; mrd = 0;
    wbq.delete();
  endtask

  task automatic step(input bit v, input logic [3:0] cmd, rs, rt, rd, input bit we, ui,
                      input logic [15:0] imm, input bit ordy, input bit wbe,
                      input logic [3:0] wbr, input logic [31:0] wbd, input bit rn);
    bit er, acc;
    logic [31:0] a, b;
    @(negedge clk);
    rst_n = rn; in_valid = v; in_cmd = cmd; in_rs = rs; in_rt = rt; in_rd = rd;
    in_we = we; in_use_imm = ui; in_imm = imm; out_ready = ordy;
    wb_en = wbe; wb_rd = wbr; wb_data = wbd;
    #1;
    er = exp_ready();
    chk("in_ready", {31'b0, in_ready}, {31'b0, er});
    @(posedge clk);
    if (!rn) begin
      model_clear();
    end else begin
      acc = v && er;
      a = srcval(rs);
      b = ui ? {{16{imm[15]}}, imm} : srcval(rt);
      if (mvalid && ordy && mwe && mrd != 0) wbq.push_back(mrd);
      if (acc) begin
        mvalid = 1; mA = a; mB = b; mcmd = cmd; mrd = rd; mwe = we;
      end else if (ordy) begin
        mvalid = 0;
      end
      if (wbe && wbr != 0) begin
        mreg[wbr] = wbd;
        mpend[wbr] = 0;
      end
      if (acc && we && rd != 0) mpend[rd] = 1;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
    chk("A", A, mA);
    chk("B", B, mB);
    chk("CMD", {28'b0, CMD}, {28'b0, mcmd});
    chk("out_rd", {28'b0, out_rd}, {28'b0, mrd});
    chk("out_we", {31'b0, out_we}, {31'b0, mwe});
  endtask

  task automatic idle(input bit ordy, input bit rn);
    step(0, 0, 0, 0, 0, 0, 0, 16'h0, ordy, 0, 0, 32'h0, rn);
  endtask

  initial begin
    logic [3:0]  r, wr;
    logic [31:0] wd;
    bit          we_b;
    int          idx;
    model_clear();
    idle(1, 0);
    idle(1, 0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_A", A, 32'h0);

    // Immediate issue into R1.
    step(1, 4'd0, 4'd0, 4'd0, 4'd1, 1, 1, 16'hFFFF, 1, 0, 0, 0, 1);
    chk("imm_B", B, 32'hFFFFFFFF);
    chk("imm_A", A, 32'h0);
    chk("imm_valid", {31'b0, out_valid}, 32'h1);
    // R1 pending: reader stalls until its writeback.
    step(1, 4'd2, 4'd1, 4'd0, 4'd2, 0, 1, 16'h5, 1, 0, 0, 0, 1);
    step(1, 4'd2, 4'd1, 4'd0, 4'd2, 0, 1, 16'h5, 1, 1, 4'd1, 32'h55, 1);
    step(1, 4'd2, 4'd1, 4'd0, 4'd2, 0, 1, 16'h5, 1, 0, 0, 0, 1);
    chk("raw1_A", A, 32'h55);

    // Back-to-back independent operations.
    for (int i = 0; i < 4; i++)
      step(1, 4'(i), 4'd2, 4'd3, 4'd6, 0, 0, 16'h0, 1, 0, 0, 0, 1);

    // RAW on R4 resolved by writeback of 0x1234.
    step(1, 4'd0, 4'd2, 4'd3, 4'd4, 1, 0, 16'h0, 1, 0, 0, 0, 1);
    step(1, 4'd3, 4'd4, 4'd0, 4'd0, 0, 0, 16'h0, 1, 0, 0, 0, 1);
    step(1, 4'd3, 4'd4, 4'd0, 4'd0, 0, 0, 16'h0, 1, 0, 0, 0, 1);
    step(1, 4'd3, 4'd4, 4'd0, 4'd0, 0, 0, 16'h0, 1, 1, 4'd4, 32'h1234, 1);
    step(1, 4'd3, 4'd4, 4'd0, 4'd0, 0, 0, 16'h0, 1, 0, 0, 0, 1);
    chk("raw4_A", A, 32'h1234);

    // Downstream back-pressure for three cycles, then release.
    step(1, 4'd5, 4'd2, 4'd3, 4'd6, 0, 0, 16'h0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 4'd7, 4'd4, 4'd0, 4'd6, 0, 1, 16'h0042, 0, 0, 0, 0, 1);
    chk("hold_CMD", {28'b0, CMD}, 32'd5);
    step(1, 4'd7, 4'd4, 4'd0, 4'd6, 0, 1, 16'h0042, 1, 0, 0, 0, 1);
    chk("rel_CMD", {28'b0, CMD}, 32'd7);
    chk("rel_B", B, 32'h42);

    // WAW on R5, then writeback to R0 is ignored.
    step(1, 4'd0, 4'd0, 4'd0, 4'd5, 1, 1, 16'h1, 1, 0, 0, 0, 1);
    step(1, 4'd1, 4'd0, 4'd0, 4'd5, 1, 1, 16'h2, 1, 0, 0, 0, 1);
    step(1, 4'd1, 4'd0, 4'd0, 4'd5, 1, 1, 16'h2, 1, 0, 0, 0, 1);
    step(1, 4'd1, 4'd0, 4'd0, 4'd5, 1, 1, 16'h2, 1, 1, 4'd5, 32'hAA, 1);
    step(1, 4'd1, 4'd0, 4'd0, 4'd5, 1, 1, 16'h2, 1, 0, 0, 0, 1);
    step(1, 4'd2, 4'd0, 4'd0, 4'd0, 1, 0, 16'h0, 1, 1, 4'd0, 32'h7, 1);
    chk("r0_A", A, 32'h0);
    step(1, 4'd2, 4'd0, 4'd0, 4'd0, 1, 0, 16'h0, 1, 0, 0, 0, 1);

    // Reset in the middle of a back-pressure stall.
    step(1, 4'd0, 4'd2, 4'd0, 4'd7, 1, 1, 16'h3, 1, 0, 0, 0, 1);
    step(1, 4'd0, 4'd7, 4'd0, 4'd8, 1, 0, 16'h0, 0, 0, 0, 0, 1);
    step(1, 4'd0, 4'd7, 4'd0, 4'd8, 1, 0, 16'h0, 0, 0, 0, 0, 0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    for (int i = 1; i < 16; i++) begin
      step(1, 4'd0, 4'(i), 4'(i), 4'd0, 0, 0, 16'h0, 1, 0, 0, 0, 1);
      chk("clr_R", A | B, 32'h0);
    end

    // Randomized traffic with an out-of-order writeback agent.
    for (int n = 0; n < 3000; n++) begin
      we_b = 0; wr = 0; wd = 0;
      if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, wbq.size() - 1);
        wr = wbq[idx];
        wbq.delete(idx);
        wd = $urandom;
        we_b = 1;
      end else if ($urandom_range(0, 15) == 0) begin
        r = 4'($urandom_range(0, 15));
        if (!mpend[r]) begin
          wr = r; wd = $urandom; we_b = 1;
        end
      end
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 3) != 0, we_b, wr, wd, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
